// File: rtl/decode_pipe.sv
// decode_pipe: per-lane RISC-V (RV32IM subset) instruction decoder followed by
// a two-entry skid buffer (main + skid register) toward the instruction queue.
//
// Handshake: a bundle moves on a channel in every cycle where valid and ready
// are both high. Once valid is raised, the sender holds the bundle stable until
// that transfer happens. in_ready depends only on registered state, so there is
// no combinational path from out_ready back to in_ready.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   flush            drop every buffered bundle and any bundle accepted this cycle
//   in_valid/ready   fetch-side handshake
//   in_lane_valid    per-lane presence, lane 0 oldest
//   in_inst, in_pc   raw instruction word and pc per lane
//   out_valid/ready  instruction-queue-side handshake
//   out_info         decoded lanes (driven from the main register)
//   out_illegal      per-lane unsupported encoding flag (valid lanes only)
//   dbg_state        buffer FSM state (0 EMPTY, 1 ONE, 2 TWO)

package decode_pkg;
    parameter int XLEN = 32;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef enum logic [2:0] {
        CMP_BEQ, CMP_BNE, CMP_BLT, CMP_BGE, CMP_BLTU, CMP_BGEU
    } cmp_op_e;

    typedef struct packed {
        logic            valid;
        logic [31:0]     inst;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rs1_s;
        logic [4:0]      rs2_s;
        logic [4:0]      rd_s;
        logic [XLEN-1:0] pc_curr;
        logic [XLEN-1:0] pc_next;
        logic [XLEN-1:0] immediate;
        logic            alu_en;
        alu_op_e         alu_op;
        logic            cmp_en;
        cmp_op_e         cmp_op;
        logic            is_branch;
        logic            is_jump;
        logic            is_load;
        logic            is_store;
        logic            is_mul;
        logic [1:0]      mul_type;
        logic            is_div;
    } instruction_info_reg_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OPREG  = 7'b0110011;
endpackage

module decode_pipe
    import decode_pkg::*;
#(
    parameter int DECODE_WIDTH = 2,
    // Must match decode_pkg::XLEN, which sizes the out_info struct fields.
    parameter int XLEN         = decode_pkg::XLEN
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    flush,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [DECODE_WIDTH-1:0]                 in_lane_valid,
    input  logic [DECODE_WIDTH-1:0][31:0]           in_inst,
    input  logic [DECODE_WIDTH-1:0][XLEN-1:0]       in_pc,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output instruction_info_reg_t [DECODE_WIDTH-1:0] out_info,
    output logic [DECODE_WIDTH-1:0]                 out_illegal,
    output logic [1:0]                              dbg_state
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    // Decode a single lane; valid is set here and masked by the caller.
    function automatic instruction_info_reg_t decode_lane(
        input  logic [31:0]     inst,
        input  logic [XLEN-1:0] pc,
        output logic            illegal
    );
        instruction_info_reg_t d;
        logic signed [31:0]    simm;
        d       = '0;
        simm    = '0;
        illegal = 1'b0;

        d.valid   = 1'b1;
        d.inst    = inst;
        d.opcode  = inst[6:0];
        d.funct3  = inst[14:12];
        d.funct7  = inst[31:25];
        d.rs1_s   = inst[19:15];
        d.rs2_s   = inst[24:20];
        d.rd_s    = inst[11:7];
        d.pc_curr = pc;
        d.pc_next = pc + XLEN'(4);

        case (inst[6:0])
            OP_LUI, OP_AUIPC: begin
                simm    = {inst[31:12], 12'b0};
                d.rs1_s = '0;
                d.rs2_s = '0;
                d.alu_en = 1'b1;
                d.alu_op = ALU_ADD;
            end
            OP_JAL: begin
                simm      = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                d.rs1_s   = '0;
                d.rs2_s   = '0;
                d.is_jump = 1'b1;
            end
            OP_JALR: begin
                simm      = {{20{inst[31]}}, inst[31:20]};
                d.rs2_s   = '0;
                d.is_jump = 1'b1;
            end
            OP_BRANCH: begin
                simm        = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                d.rd_s      = '0;
                d.is_branch = 1'b1;
                d.cmp_en    = 1'b1;
                case (inst[14:12])
                    3'b001:  d.cmp_op = CMP_BNE;
                    3'b100:  d.cmp_op = CMP_BLT;
                    3'b101:  d.cmp_op = CMP_BGE;
                    3'b110:  d.cmp_op = CMP_BLTU;
                    3'b111:  d.cmp_op = CMP_BGEU;
                    default: d.cmp_op = CMP_BEQ;
                endcase
            end
            OP_LOAD: begin
                simm      = {{20{inst[31]}}, inst[31:20]};
                d.rs2_s   = '0;
                d.is_load = 1'b1;
                d.alu_en  = 1'b1;
                d.alu_op  = ALU_ADD;
            end
            OP_STORE: begin
                simm       = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                d.rd_s     = '0;
                d.is_store = 1'b1;
                d.alu_en   = 1'b1;
                d.alu_op   = ALU_ADD;
            end
            OP_OPIMM, OP_OPREG: begin
                if (inst[6:0] == OP_OPIMM) begin
                    simm    = {{20{inst[31]}}, inst[31:20]};
                    d.rs2_s = '0;
                end
                if (inst[6:0] == OP_OPREG && inst[31:25] == 7'b0000001) begin
                    // M extension: multiplier/divider, no ALU or comparator.
                    if (!inst[14]) begin
                        d.is_mul = 1'b1;
                        case (inst[13:12])
                            2'b10:   d.mul_type = 2'b10;
                            2'b11:   d.mul_type = 2'b00;
                            default: d.mul_type = 2'b01;
                        endcase
                    end else begin
                        d.is_div = 1'b1;
                    end
                end else begin
                    if (inst[6:0] == OP_OPREG && inst[31:25] != 7'b0000000 &&
                        inst[31:25] != 7'b0100000) begin
                        illegal = 1'b1;
                    end
                    d.alu_en = 1'b1;
                    case (inst[14:12])
                        // Only op-reg has a subtract form; addi ignores inst[30].
                        3'b000: d.alu_op = (inst[6:0] == OP_OPREG && inst[30]) ? ALU_SUB : ALU_ADD;
                        3'b001: d.alu_op = ALU_SLL;
                        3'b010: begin
                            d.alu_en = 1'b0;
                            d.cmp_en = 1'b1;
                            d.cmp_op = CMP_BLT;
                        end
                        3'b011: begin
                            d.alu_en = 1'b0;
                            d.cmp_en = 1'b1;
                            d.cmp_op = CMP_BLTU;
                        end
                        3'b100: d.alu_op = ALU_XOR;
                        3'b101: d.alu_op = inst[30] ? ALU_SRA : ALU_SRL;
                        3'b110: d.alu_op = ALU_OR;
                        default: d.alu_op = ALU_AND;
                    endcase
                end
            end
            default: illegal = 1'b1;
        endcase

        d.immediate = simm;
        return d;
    endfunction

    state_e                                 r_state;
    state_e                                 w_next_state;
    instruction_info_reg_t [DECODE_WIDTH-1:0] r_main_info;
    instruction_info_reg_t [DECODE_WIDTH-1:0] r_skid_info;
    logic [DECODE_WIDTH-1:0]                r_main_ill;
    logic [DECODE_WIDTH-1:0]                r_skid_ill;

    instruction_info_reg_t [DECODE_WIDTH-1:0] w_lane_info;
    logic [DECODE_WIDTH-1:0]                w_lane_ill;
    logic [DECODE_WIDTH-1:0]                w_raw_ill;
    logic                                   w_alive;
    logic                                   w_lane_ok;
    logic                                   w_in_xfer;
    logic                                   w_out_xfer;
    logic                                   w_load_main_in;
    logic                                   w_load_main_skid;
    logic                                   w_load_skid;

    // Lane decode with masking: the first absent lane, or a lane after a
    // valid jump, ends the bundle.
    always_comb begin
        w_lane_info = '0;
        w_lane_ill  = '0;
        w_raw_ill   = '0;
        w_alive     = 1'b1;
        w_lane_ok   = 1'b0;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            w_lane_info[i]       = decode_lane(in_inst[i], in_pc[i], w_raw_ill[i]);
            w_lane_ok            = w_alive & in_lane_valid[i];
            w_lane_info[i].valid = w_lane_ok;
            w_lane_ill[i]        = w_lane_ok & w_raw_ill[i];
            w_alive              = w_lane_ok & ~w_lane_info[i].is_jump;
        end
    end

    assign in_ready   = (r_state != ST_TWO);
    assign out_valid  = (r_state != ST_EMPTY);
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    always_comb begin
        w_next_state     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_xfer) begin
                    w_next_state   = ST_ONE;
                    w_load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_load_main_in = 1'b1;
                end else if (w_in_xfer) begin
                    w_next_state = ST_TWO;
                    w_load_skid  = 1'b1;
                end else if (w_out_xfer) begin
                    w_next_state = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_out_xfer) begin
                    w_next_state     = ST_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: w_next_state = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else if (flush) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_info <= '0;
            r_skid_info <= '0;
            r_main_ill  <= '0;
            r_skid_ill  <= '0;
        end else if (flush) begin
            r_main_info <= '0;
            r_skid_info <= '0;
            r_main_ill  <= '0;
            r_skid_ill  <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main_info <= w_lane_info;
                r_main_ill  <= w_lane_ill;
            end else if (w_load_main_skid) begin
                r_main_info <= r_skid_info;
                r_main_ill  <= r_skid_ill;
            end
            if (w_load_skid) begin
                r_skid_info <= w_lane_info;
                r_skid_ill  <= w_lane_ill;
            end
        end
    end

    assign out_info    = r_main_info;
    assign out_illegal = r_main_ill;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed testbench for decode_pipe (DECODE_WIDTH=2, XLEN=32).
module tb_decode_pipe;
    import decode_pkg::*;

    logic                        clk;
    logic                        rst_n;
    logic                        flush;
    logic                        in_valid;
    logic                        in_ready;
    logic [1:0]                  in_lane_valid;
    logic [1:0][31:0]            in_inst;
    logic [1:0][31:0]            in_pc;
    logic                        out_valid;
    logic                        out_ready;
    instruction_info_reg_t [1:0] out_info;
    logic [1:0]                  out_illegal;
    logic [1:0]                  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] I_ADDI  = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] I_ADD   = 32'h0010_8133; // add  x2,x1,x1
    localparam logic [31:0] I_JAL   = 32'h0080_00EF; // jal  x1,+8
    localparam logic [31:0] I_BEQ   = 32'hFE20_8EE3; // beq  x1,x2,-4
    localparam logic [31:0] I_SW    = 32'h0020_A223; // sw   x2,4(x1)
    localparam logic [31:0] I_LUI   = 32'h1234_52B7; // lui  x5,0x12345
    localparam logic [31:0] I_AUIPC = 32'h0000_1317; // auipc x6,1
    localparam logic [31:0] I_MULHU = 32'h0220_B1B3; // mulhu x3,x1,x2
    localparam logic [31:0] I_SLT   = 32'h0020_A1B3; // slt  x3,x1,x2
    localparam logic [31:0] I_DIV   = 32'h0220_C1B3; // div  x3,x1,x2
    localparam logic [31:0] I_SUB   = 32'h4020_81B3; // sub  x3,x1,x2
    localparam logic [31:0] I_BADF7 = 32'h0420_81B3; // op-reg funct7=0000010
    localparam logic [31:0] I_A     = 32'h0010_0093; // addi x1,x0,1
    localparam logic [31:0] I_B     = 32'h0020_0093; // addi x1,x0,2
    localparam logic [31:0] I_C     = 32'h0030_0093; // addi x1,x0,3
    localparam logic [31:0] I_D     = 32'h0040_0093; // addi x1,x0,4

    decode_pipe #(.DECODE_WIDTH(2), .XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_lane_valid (in_lane_valid),
        .in_inst       (in_inst),
        .in_pc         (in_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_info      (out_info),
        .out_illegal   (out_illegal),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bundle(input logic [1:0] lv, input logic [31:0] i0,
                              input logic [31:0] i1, input logic [31:0] pc0);
        in_valid      = 1'b1;
        in_lane_valid = lv;
        in_inst[0]    = i0;
        in_inst[1]    = i1;
        in_pc[0]      = pc0;
        in_pc[1]      = pc0 + 32'd4;
    endtask

    task automatic push_one(input logic [1:0] lv, input logic [31:0] i0,
                            input logic [31:0] i1, input logic [31:0] pc0);
        set_bundle(lv, i0, i1, pc0);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_lane_valid = 2'b00; in_inst = '0; in_pc = '0;
        rst_n = 1'b0;
        #12;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b exp 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b exp 1", in_ready); end
        n_tests++; if (out_illegal !== 2'b00) begin n_fail++; $display("FAIL reset_illegal: got %b exp 00", out_illegal); end
        n_tests++; if ({out_info[1].valid, out_info[0].valid} !== 2'b00) begin n_fail++; $display("FAIL reset_info_valid: got %b exp 00", {out_info[1].valid, out_info[0].valid}); end
        n_tests++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        push_one(2'b11, I_ADDI, I_ADD, 32'h100);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %0b exp 1", out_valid); end
        n_tests++; if ({out_info[1].valid, out_info[0].valid} !== 2'b11) begin n_fail++; $display("FAIL basic_lane_valid: got %b exp 11", {out_info[1].valid, out_info[0].valid}); end
        n_tests++; if (out_info[0].immediate !== 32'd5) begin n_fail++; $display("FAIL basic_imm0: got %h exp 5", out_info[0].immediate); end
        n_tests++; if (out_info[0].rs2_s !== 5'd0) begin n_fail++; $display("FAIL basic_rs2_0: got %0d exp 0", out_info[0].rs2_s); end
        n_tests++; if (out_info[0].rd_s !== 5'd1) begin n_fail++; $display("FAIL basic_rd0: got %0d exp 1", out_info[0].rd_s); end
        n_tests++; if (out_info[1].alu_op !== ALU_ADD || out_info[1].alu_en !== 1'b1) begin n_fail++; $display("FAIL basic_alu1: got op %0d en %0b exp op 0 en 1", out_info[1].alu_op, out_info[1].alu_en); end
        n_tests++; if (out_info[1].rs1_s !== 5'd1 || out_info[1].rs2_s !== 5'd1 || out_info[1].rd_s !== 5'd2) begin n_fail++; $display("FAIL basic_regs1: got %0d %0d %0d exp 1 1 2", out_info[1].rs1_s, out_info[1].rs2_s, out_info[1].rd_s); end
        n_tests++; if (out_info[1].pc_curr !== 32'h104 || out_info[1].pc_next !== 32'h108) begin n_fail++; $display("FAIL basic_pc1: got %h %h exp 104 108", out_info[1].pc_curr, out_info[1].pc_next); end
        n_tests++; if (out_illegal !== 2'b00) begin n_fail++; $display("FAIL basic_illegal: got %b exp 00", out_illegal); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %0b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        set_bundle(2'b01, I_A, I_ADD, 32'h200);
        tick();
        n_tests++; if (in_ready !== 1'b1 || dbg_state !== 2'd1) begin n_fail++; $display("FAIL bp_cycle1: got ready %0b state %0d exp 1 1", in_ready, dbg_state); end
        set_bundle(2'b01, I_B, I_ADD, 32'h210);
        tick();
        n_tests++; if (in_ready !== 1'b0 || dbg_state !== 2'd2) begin n_fail++; $display("FAIL bp_cycle2: got ready %0b state %0d exp 0 2", in_ready, dbg_state); end
        set_bundle(2'b01, I_C, I_ADD, 32'h220);
        tick();
        n_tests++; if (in_ready !== 1'b0 || out_info[0].inst !== I_A) begin n_fail++; $display("FAIL bp_cycle3: got ready %0b inst %h exp 0 %h", in_ready, out_info[0].inst, I_A); end
        n_tests++; if (out_info[1].valid !== 1'b0) begin n_fail++; $display("FAIL bp_lane1_masked: got %0b exp 0", out_info[1].valid); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_info[0].inst !== I_B) begin n_fail++; $display("FAIL bp_second: got valid %0b inst %h exp 1 %h", out_valid, out_info[0].inst, I_B); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_third: got %0b exp 0 (C was offered while full)", out_valid); end
    endtask

    task automatic test_lane_mask();
        out_ready = 1'b1;
        push_one(2'b11, I_JAL, I_ADD, 32'h300);
        n_tests++; if (out_info[0].is_jump !== 1'b1 || out_info[0].cmp_en !== 1'b0) begin n_fail++; $display("FAIL jal_jump: got jump %0b cmp %0b exp 1 0", out_info[0].is_jump, out_info[0].cmp_en); end
        n_tests++; if (out_info[0].immediate !== 32'd8) begin n_fail++; $display("FAIL jal_imm: got %h exp 8", out_info[0].immediate); end
        n_tests++; if (out_info[0].rs1_s !== 5'd0 || out_info[0].rs2_s !== 5'd0 || out_info[0].rd_s !== 5'd1) begin n_fail++; $display("FAIL jal_regs: got %0d %0d %0d exp 0 0 1", out_info[0].rs1_s, out_info[0].rs2_s, out_info[0].rd_s); end
        n_tests++; if (out_info[1].valid !== 1'b0 || out_illegal !== 2'b00) begin n_fail++; $display("FAIL jal_kill: got valid1 %0b ill %b exp 0 00", out_info[1].valid, out_illegal); end
        push_one(2'b10, I_ADD, I_ADD, 32'h310);
        n_tests++; if ({out_info[1].valid, out_info[0].valid} !== 2'b00) begin n_fail++; $display("FAIL mask_hole: got %b exp 00", {out_info[1].valid, out_info[0].valid}); end
        tick();
    endtask

    task automatic test_imm_types();
        out_ready = 1'b1;
        push_one(2'b11, I_BEQ, I_SW, 32'h400);
        n_tests++; if (out_info[0].immediate !== 32'hFFFF_FFFC || out_info[0].rd_s !== 5'd0) begin n_fail++; $display("FAIL beq_imm_rd: got %h %0d exp fffffffc 0", out_info[0].immediate, out_info[0].rd_s); end
        n_tests++; if (out_info[0].is_branch !== 1'b1 || out_info[0].cmp_en !== 1'b1 || out_info[0].cmp_op !== CMP_BEQ) begin n_fail++; $display("FAIL beq_cmp: got br %0b en %0b op %0d exp 1 1 0", out_info[0].is_branch, out_info[0].cmp_en, out_info[0].cmp_op); end
        n_tests++; if (out_info[1].immediate !== 32'd4 || out_info[1].rd_s !== 5'd0 || out_info[1].is_store !== 1'b1) begin n_fail++; $display("FAIL sw_fields: got %h %0d %0b exp 4 0 1", out_info[1].immediate, out_info[1].rd_s, out_info[1].is_store); end
        push_one(2'b11, I_LUI, I_AUIPC, 32'h410);
        n_tests++; if (out_info[0].immediate !== 32'h1234_5000 || out_info[0].rs1_s !== 5'd0 || out_info[0].rs2_s !== 5'd0) begin n_fail++; $display("FAIL lui_fields: got %h %0d %0d exp 12345000 0 0", out_info[0].immediate, out_info[0].rs1_s, out_info[0].rs2_s); end
        n_tests++; if (out_info[1].immediate !== 32'h0000_1000 || out_info[1].rd_s !== 5'd6) begin n_fail++; $display("FAIL auipc_fields: got %h %0d exp 1000 6", out_info[1].immediate, out_info[1].rd_s); end
        tick();
    endtask

    task automatic test_mul_illegal();
        out_ready = 1'b1;
        push_one(2'b11, I_MULHU, 32'h0000_0000, 32'h500);
        n_tests++; if (out_info[0].is_mul !== 1'b1 || out_info[0].mul_type !== 2'b00 || out_info[0].alu_en !== 1'b0) begin n_fail++; $display("FAIL mulhu: got mul %0b type %b alu %0b exp 1 00 0", out_info[0].is_mul, out_info[0].mul_type, out_info[0].alu_en); end
        n_tests++; if (out_illegal !== 2'b10 || out_info[1].valid !== 1'b1) begin n_fail++; $display("FAIL zero_opcode_illegal: got ill %b valid1 %0b exp 10 1", out_illegal, out_info[1].valid); end
        push_one(2'b11, I_SLT, I_DIV, 32'h510);
        n_tests++; if (out_info[0].cmp_en !== 1'b1 || out_info[0].cmp_op !== CMP_BLT || out_info[0].alu_en !== 1'b0) begin n_fail++; $display("FAIL slt_cmp: got en %0b op %0d alu %0b exp 1 2 0", out_info[0].cmp_en, out_info[0].cmp_op, out_info[0].alu_en); end
        n_tests++; if (out_info[1].is_div !== 1'b1 || out_info[1].is_mul !== 1'b0 || out_info[1].cmp_en !== 1'b0) begin n_fail++; $display("FAIL div: got div %0b mul %0b cmp %0b exp 1 0 0", out_info[1].is_div, out_info[1].is_mul, out_info[1].cmp_en); end
        push_one(2'b11, I_SUB, I_BADF7, 32'h520);
        n_tests++; if (out_info[0].alu_op !== ALU_SUB) begin n_fail++; $display("FAIL sub_op: got %0d exp 1", out_info[0].alu_op); end
        n_tests++; if (out_illegal !== 2'b10) begin n_fail++; $display("FAIL bad_funct7: got %b exp 10", out_illegal); end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        push_one(2'b01, I_A, I_ADD, 32'h600);
        push_one(2'b01, I_B, I_ADD, 32'h610);
        n_tests++; if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL flush_setup: got state %0d exp 2", dbg_state); end
        set_bundle(2'b01, I_D, I_ADD, 32'h620);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_after: got valid %0b ready %0b exp 0 1", out_valid, in_ready); end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: cycle %0d got valid %0b inst %h exp 0", k, out_valid, out_info[0].inst); end
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        push_one(2'b01, I_A, I_ADD, 32'h700);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL areset_setup: got %0b exp 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_info[0].valid !== 1'b0) begin n_fail++; $display("FAIL areset_immediate: got valid %0b ready %0b lane0 %0b exp 0 1 0", out_valid, in_ready, out_info[0].valid); end
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        push_one(2'b01, I_C, I_ADD, 32'h710);
        n_tests++; if (out_valid !== 1'b1 || out_info[0].inst !== I_C) begin n_fail++; $display("FAIL areset_resume: got valid %0b inst %h exp 1 %h", out_valid, out_info[0].inst, I_C); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_lane_mask();
        test_imm_types();
        test_mul_illegal();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
